// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter.
//   XLEN / STRB      : data/address width and byte-enable width
//   arb_state_e      : arbiter FSM state encoding
//   pend_entry_t     : one buffered request {valid, addr, wdata, wstrb}
//   PEND_INIT        : empty pending entry
package memory_arbiter_pkg;

   localparam int XLEN = 32;
   localparam int STRB = XLEN / 8;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_IBUSY = 2'd1,
      ARB_DBUSY = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
      logic [STRB-1:0] wstrb;
   } pend_entry_t;

   localparam pend_entry_t PEND_INIT = '{valid: 1'b0, addr: '0, wdata: '0, wstrb: '0};

endpackage

// File: rtl/memory_arbiter_pending_buffer.sv
// One-entry pending request register.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   capture_i             : load addr_i/wdata_i/wstrb_i (overwrites any held entry)
//   clear_i               : drop the held entry (capture wins if both are set)
//   addr_i/wdata_i/wstrb_i: request fields to capture
//   entry_o               : held entry, valid flag included
module arbiter_pending_buffer
   import memory_arbiter_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic            capture_i,
   input  logic            clear_i,
   input  logic [XLEN-1:0] addr_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [STRB-1:0] wstrb_i,
   output pend_entry_t     entry_o
);

   pend_entry_t entry_q;

   // A new request arriving in the same cycle the old entry is granted must
   // survive, so capture takes priority over clear.
   always_ff @(posedge clock) begin
      if (reset) begin
         entry_q <= PEND_INIT;
      end else if (capture_i) begin
         entry_q <= '{valid: 1'b1, addr: addr_i, wdata: wdata_i, wstrb: wstrb_i};
      end else if (clear_i) begin
         entry_q <= PEND_INIT;
      end
   end

   assign entry_o = entry_q;

endmodule

// File: rtl/memory_arbiter.sv
// Shares one memory bus port between instruction fetch (i_*) and load/store (d_*).
// One bus transaction outstanding at a time; one pending request buffered per side.
//   clock, reset                    : rising-edge clock, synchronous active-high reset
//   i_valid/i_addr                  : fetch request pulse and address
//   i_ready/i_error/i_rdata         : fetch response pulse, fault, data
//   d_valid/d_addr/d_wdata/d_wstrb  : load/store request pulse (wstrb 0 = load)
//   d_ready/d_error/d_rdata         : data response pulse, fault, data
//   m_valid/m_instr/m_addr/m_wdata/m_wstrb : bus request pulse and fields
//   m_ready/m_error/m_rdata         : bus response pulse, fault, data
//
// state | meaning
// IDLE  | no bus transaction outstanding; grant happens here
// IBUSY | fetch outstanding on the bus, waiting for m_ready
// DBUSY | load/store outstanding on the bus, waiting for m_ready
module memory_arbiter
   import memory_arbiter_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic            i_valid,
   input  logic [XLEN-1:0] i_addr,
   output logic            i_ready,
   output logic            i_error,
   output logic [XLEN-1:0] i_rdata,
   input  logic            d_valid,
   input  logic [XLEN-1:0] d_addr,
   input  logic [XLEN-1:0] d_wdata,
   input  logic [STRB-1:0] d_wstrb,
   output logic            d_ready,
   output logic            d_error,
   output logic [XLEN-1:0] d_rdata,
   output logic            m_valid,
   output logic            m_instr,
   output logic [XLEN-1:0] m_addr,
   output logic [XLEN-1:0] m_wdata,
   output logic [STRB-1:0] m_wstrb,
   input  logic            m_ready,
   input  logic            m_error,
   input  logic [XLEN-1:0] m_rdata
);

   arb_state_e  state_q, state_d;
   pend_entry_t i_pend, d_pend;

   logic idle;
   logic i_cand, d_cand;
   logic grant_i, grant_d;
   logic i_capture, i_clear, d_capture, d_clear;
   logic i_resp, d_resp;

   arbiter_pending_buffer u_i_pend (
      .clock     (clock),
      .reset     (reset),
      .capture_i (i_capture),
      .clear_i   (i_clear),
      .addr_i    (i_addr),
      .wdata_i   ('0),
      .wstrb_i   ('0),
      .entry_o   (i_pend)
   );

   arbiter_pending_buffer u_d_pend (
      .clock     (clock),
      .reset     (reset),
      .capture_i (d_capture),
      .clear_i   (d_clear),
      .addr_i    (d_addr),
      .wdata_i   (d_wdata),
      .wstrb_i   (d_wstrb),
      .entry_o   (d_pend)
   );

   // Outputs are gated by reset so a request or response seen in the reset
   // cycle never escapes; the in-flight transaction is simply forgotten.
   always_comb begin
      idle    = (state_q == ARB_IDLE);
      d_cand  = d_pend.valid | d_valid;
      i_cand  = i_pend.valid | i_valid;
      grant_d = ~reset & idle & d_cand;
      grant_i = ~reset & idle & ~d_cand & i_cand;

      // A new pulse is buffered unless it is the exact request being granted;
      // a held entry always beats a new pulse on the same side.
      d_capture = d_valid & ~(grant_d & ~d_pend.valid);
      i_capture = i_valid & ~(grant_i & ~i_pend.valid);
      d_clear   = grant_d & d_pend.valid;
      i_clear   = grant_i & i_pend.valid;

      i_resp = ~reset & (state_q == ARB_IBUSY) & m_ready;
      d_resp = ~reset & (state_q == ARB_DBUSY) & m_ready;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE: begin
            if (grant_d) begin
               state_d = ARB_DBUSY;
            end else if (grant_i) begin
               state_d = ARB_IBUSY;
            end
         end
         ARB_IBUSY: if (m_ready) state_d = ARB_IDLE;
         ARB_DBUSY: if (m_ready) state_d = ARB_IDLE;
         default:   state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      m_valid = grant_d | grant_i;
      m_instr = grant_i;
      m_addr  = '0;
      m_wdata = '0;
      m_wstrb = '0;
      if (grant_d) begin
         m_addr  = d_pend.valid ? d_pend.addr  : d_addr;
         m_wdata = d_pend.valid ? d_pend.wdata : d_wdata;
         m_wstrb = d_pend.valid ? d_pend.wstrb : d_wstrb;
      end else if (grant_i) begin
         m_addr  = i_pend.valid ? i_pend.addr  : i_addr;
         m_wdata = i_pend.valid ? i_pend.wdata : '0;
         m_wstrb = i_pend.valid ? i_pend.wstrb : '0;
      end
   end

   always_comb begin
      i_ready = i_resp;
      i_error = i_resp & m_error;
      i_rdata = i_resp ? m_rdata : '0;
      d_ready = d_resp;
      d_error = d_resp & m_error;
      d_rdata = d_resp ? m_rdata : '0;
   end

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        i_valid = 1'b0;
   logic [31:0] i_addr = '0;
   logic        i_ready, i_error;
   logic [31:0] i_rdata;
   logic        d_valid = 1'b0;
   logic [31:0] d_addr = '0, d_wdata = '0;
   logic [3:0]  d_wstrb = '0;
   logic        d_ready, d_error;
   logic [31:0] d_rdata;
   logic        m_valid, m_instr;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_ready = 1'b0, m_error = 1'b0;
   logic [31:0] m_rdata = '0;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   memory_arbiter dut (
      .clock   (clock),
      .reset   (reset),
      .i_valid (i_valid),
      .i_addr  (i_addr),
      .i_ready (i_ready),
      .i_error (i_error),
      .i_rdata (i_rdata),
      .d_valid (d_valid),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_wstrb (d_wstrb),
      .d_ready (d_ready),
      .d_error (d_error),
      .d_rdata (d_rdata),
      .m_valid (m_valid),
      .m_instr (m_instr),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_wstrb (m_wstrb),
      .m_ready (m_ready),
      .m_error (m_error),
      .m_rdata (m_rdata)
   );

   typedef struct {
      string       name;
      logic        rst;
      logic        iv;
      logic [31:0] ia;
      logic        dv;
      logic [31:0] da;
      logic [31:0] dw;
      logic [3:0]  ds;
      logic        mr;
      logic        me;
      logic [31:0] md;
      logic [144:0] exp;
   } vec_t;

   vec_t tbl[$];

   // Expected outputs packed as {m_valid,m_instr,m_addr,m_wdata,m_wstrb,
   // i_ready,i_error,i_rdata,d_ready,d_error,d_rdata}.
   function automatic logic [144:0] outs(logic mv, logic mi, logic [31:0] ma, logic [31:0] mw,
                                         logic [3:0] ms, logic ir, logic ie, logic [31:0] id,
                                         logic dr, logic de, logic [31:0] dd);
      return {mv, mi, ma, mw, ms, ir, ie, id, dr, de, dd};
   endfunction

   function automatic vec_t mk(string name, logic rst, logic iv, logic [31:0] ia,
                               logic dv, logic [31:0] da, logic [31:0] dw, logic [3:0] ds,
                               logic mr, logic me, logic [31:0] md, logic [144:0] exp);
      vec_t v;
      v.name = name; v.rst = rst; v.iv = iv; v.ia = ia; v.dv = dv; v.da = da;
      v.dw = dw; v.ds = ds; v.mr = mr; v.me = me; v.md = md; v.exp = exp;
      return v;
   endfunction

   localparam logic [144:0] ZERO = '0;

   task automatic apply(vec_t v);
      logic [144:0] got;
      @(negedge clock);
      reset   = v.rst;
      i_valid = v.iv;  i_addr  = v.ia;
      d_valid = v.dv;  d_addr  = v.da; d_wdata = v.dw; d_wstrb = v.ds;
      m_ready = v.mr;  m_error = v.me; m_rdata = v.md;
      #1;
      got = {m_valid, m_instr, m_addr, m_wdata, m_wstrb,
             i_ready, i_error, i_rdata, d_ready, d_error, d_rdata};
      checks++;
      if (got !== v.exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", v.name, got, v.exp);
      end
   endtask

   initial begin
      // name, rst, iv, ia, dv, da, dw, ds, mr, me, md, expected
      tbl.push_back(mk("reset",        1, 0, 0,      0, 0, 0, 0,  0, 0, 0, ZERO));
      tbl.push_back(mk("idle_quiet",   0, 0, 0,      0, 0, 0, 0,  0, 0, 0, ZERO));
      // single fetch
      tbl.push_back(mk("fetch_grant",  0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0,
                       outs(1, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mk("fetch_wait",   0, 0, 0,      0, 0, 0, 0,  0, 0, 0, ZERO));
      tbl.push_back(mk("fetch_resp",   0, 0, 0,      0, 0, 0, 0,  1, 0, 32'h13,
                       outs(0, 0, 0, 0, 0, 1, 0, 32'h13, 0, 0, 0)));
      // simultaneous I and D: D first, I from buffer after a dead cycle
      tbl.push_back(mk("both_d_wins",  0, 1, 32'h104, 1, 32'h200, 32'hDEADBEEF, 4'hF, 0, 0, 0,
                       outs(1, 0, 32'h200, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mk("both_d_resp",  0, 0, 0,      0, 0, 0, 0,  1, 0, 0,
                       outs(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)));
      tbl.push_back(mk("both_i_issue", 0, 0, 0,      0, 0, 0, 0,  0, 0, 0,
                       outs(1, 1, 32'h104, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mk("both_i_resp",  0, 0, 0,      0, 0, 0, 0,  1, 0, 32'hAAAA5555,
                       outs(0, 0, 0, 0, 0, 1, 0, 32'hAAAA5555, 0, 0, 0)));
      // d_valid while IBUSY
      tbl.push_back(mk("ib_fetch",     0, 1, 32'h108, 0, 0, 0, 0, 0, 0, 0,
                       outs(1, 1, 32'h108, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mk("ib_d_held",    0, 0, 0,      1, 32'h300, 32'h12345678, 4'h3, 0, 0, 0, ZERO));
      tbl.push_back(mk("ib_wait",      0, 0, 0,      0, 0, 0, 0,  0, 0, 0, ZERO));
      tbl.push_back(mk("ib_i_resp",    0, 0, 0,      0, 0, 0, 0,  1, 0, 32'h11,
                       outs(0, 0, 0, 0, 0, 1, 0, 32'h11, 0, 0, 0)));
      tbl.push_back(mk("ib_d_issue",   0, 0, 0,      0, 0, 0, 0,  0, 0, 0,
                       outs(1, 0, 32'h300, 32'h12345678, 4'h3, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mk("ib_d_resp",    0, 0, 0,      0, 0, 0, 0,  1, 0, 32'h5A,
                       outs(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h5A)));
      // bus error on a load
      tbl.push_back(mk("err_load",     0, 0, 0,      1, 32'hFFFF0000, 0, 0, 0, 0, 0,
                       outs(1, 0, 32'hFFFF0000, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mk("err_resp",     0, 0, 0,      0, 0, 0, 0,  1, 1, 0,
                       outs(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0)));
      tbl.push_back(mk("err_next_i",   0, 1, 32'h10C, 0, 0, 0, 0, 0, 0, 0,
                       outs(1, 1, 32'h10C, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mk("err_next_rsp", 0, 0, 0,      0, 0, 0, 0,  1, 0, 32'h22,
                       outs(0, 0, 0, 0, 0, 1, 0, 32'h22, 0, 0, 0)));
      // stale m_ready in IDLE
      tbl.push_back(mk("stale_ready",  0, 0, 0,      0, 0, 0, 0,  1, 1, 32'hFFFFFFFF, ZERO));
      tbl.push_back(mk("stale_after",  0, 1, 32'h110, 0, 0, 0, 0, 0, 0, 0,
                       outs(1, 1, 32'h110, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mk("stale_resp",   0, 0, 0,      0, 0, 0, 0,  1, 0, 32'h33,
                       outs(0, 0, 0, 0, 0, 1, 0, 32'h33, 0, 0, 0)));
      // overwrite (latest wins) and pending beats new pulse on same side
      tbl.push_back(mk("ow_d",         0, 0, 0,      1, 32'h500, 0, 0, 0, 0, 0,
                       outs(1, 0, 32'h500, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mk("ow_i1",        0, 1, 32'h120, 0, 0, 0, 0, 0, 0, 0, ZERO));
      tbl.push_back(mk("ow_i2",        0, 1, 32'h124, 0, 0, 0, 0, 0, 0, 0, ZERO));
      tbl.push_back(mk("ow_d_resp",    0, 0, 0,      0, 0, 0, 0,  1, 0, 32'h66,
                       outs(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h66)));
      tbl.push_back(mk("pend_beats",   0, 1, 32'h128, 0, 0, 0, 0, 0, 0, 0,
                       outs(1, 1, 32'h124, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mk("pend_resp1",   0, 0, 0,      0, 0, 0, 0,  1, 0, 32'h77,
                       outs(0, 0, 0, 0, 0, 1, 0, 32'h77, 0, 0, 0)));
      tbl.push_back(mk("pend_new",     0, 0, 0,      0, 0, 0, 0,  0, 0, 0,
                       outs(1, 1, 32'h128, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mk("pend_resp2",   0, 0, 0,      0, 0, 0, 0,  1, 0, 32'h88,
                       outs(0, 0, 0, 0, 0, 1, 0, 32'h88, 0, 0, 0)));
      // D request in the same cycle IBUSY completes: one dead cycle, then D
      tbl.push_back(mk("b2b_i",        0, 1, 32'h12C, 0, 0, 0, 0, 0, 0, 0,
                       outs(1, 1, 32'h12C, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mk("b2b_done_d",   0, 0, 0,      1, 32'h600, 0, 0, 1, 0, 32'h99,
                       outs(0, 0, 0, 0, 0, 1, 0, 32'h99, 0, 0, 0)));
      tbl.push_back(mk("b2b_d_issue",  0, 0, 0,      0, 0, 0, 0,  0, 0, 0,
                       outs(1, 0, 32'h600, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mk("b2b_d_resp",   0, 0, 0,      0, 0, 0, 0,  1, 0, 32'hAB,
                       outs(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hAB)));

      foreach (tbl[k]) apply(tbl[k]);

      // Reset while DBUSY with a fetch pending: everything is dropped.
      apply(mk("rst_d_grant",  0, 0, 0,      1, 32'h400, 32'h5, 4'hF, 0, 0, 0,
               outs(1, 0, 32'h400, 32'h5, 4'hF, 0, 0, 0, 0, 0, 0)));
      apply(mk("rst_i_held",   0, 1, 32'h114, 0, 0, 0, 0, 0, 0, 0, ZERO));
      apply(mk("rst_assert",   1, 0, 0,      0, 0, 0, 0,  0, 0, 0, ZERO));
      apply(mk("rst_no_pend",  0, 0, 0,      0, 0, 0, 0,  0, 0, 0, ZERO));
      apply(mk("rst_late_rdy", 0, 0, 0,      0, 0, 0, 0,  1, 0, 32'h44, ZERO));
      apply(mk("rst_next_i",   0, 1, 32'h118, 0, 0, 0, 0, 0, 0, 0,
               outs(1, 1, 32'h118, 0, 0, 0, 0, 0, 0, 0, 0)));
      apply(mk("rst_next_rsp", 0, 0, 0,      0, 0, 0, 0,  1, 0, 32'h55,
               outs(0, 0, 0, 0, 0, 1, 0, 32'h55, 0, 0, 0)));

      // Reset in the middle of a fetch response cycle drops that response.
      apply(mk("rsti_fetch",   0, 1, 32'h130, 0, 0, 0, 0, 0, 0, 0,
               outs(1, 1, 32'h130, 0, 0, 0, 0, 0, 0, 0, 0)));
      apply(mk("rsti_on_rdy",  1, 0, 0,      0, 0, 0, 0,  1, 0, 32'h66, ZERO));
      apply(mk("rsti_idle",    0, 0, 0,      0, 0, 0, 0,  1, 0, 32'h67, ZERO));

      @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
